// File: rtl/led_pattern_gen.sv
// LED pattern generator: prescaled stepping through GRAY, BINARY, SCAN and BREATHE patterns.
// The LED drive and step pulse are registered; en=0 freezes every piece of state.
module led_pattern_gen #(
    parameter int N_LEDS    = 4,
    parameter int LOG2DELAY = 23,
    parameter int PWM_BITS  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [1:0]        mode,
    output logic [N_LEDS-1:0] led,
    output logic              step
);

    localparam int POS_W = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;
    localparam logic [POS_W-1:0] POS_MAX = POS_W'(N_LEDS - 1);
    localparam logic [PWM_BITS-1:0] DUTY_MAX = {PWM_BITS{1'b1}};
    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    typedef enum logic [1:0] {
        MODE_GRAY    = 2'd0,
        MODE_BINARY  = 2'd1,
        MODE_SCAN    = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_e;

    logic [LOG2DELAY-1:0] prescaler_q, prescaler_d;
    logic [PWM_BITS-1:0]  pwm_q, pwm_d;
    logic [PWM_BITS-1:0]  duty_q, duty_d;
    logic [N_LEDS-1:0]    cnt_q, cnt_d;
    logic [POS_W-1:0]     pos_q, pos_d;
    logic                 dir_q, dir_d;
    mode_e                mode_q, mode_d;
    logic [N_LEDS-1:0]    led_q, led_d;
    logic                 step_q, step_d;

    logic                 tick_s;
    mode_e                mode_in_s;
    logic [N_LEDS-1:0]    pattern_s;

    assign led       = led_q;
    assign step      = step_q;
    assign mode_in_s = mode_e'(mode);

    // LED pattern decoded from the current mode and pattern state
    always_comb begin
        pattern_s = '0;
        case (mode_q)
            MODE_GRAY:    pattern_s = cnt_q ^ (cnt_q >> 1'b1);
            MODE_BINARY:  pattern_s = cnt_q;
            MODE_SCAN:    pattern_s = N_LEDS'(1'b1) << pos_q;
            MODE_BREATHE: pattern_s = {N_LEDS{pwm_q < duty_q}};
            default:      pattern_s = '0;
        endcase
    end

    // Next-state logic: prescaler/pwm free-run while enabled, pattern state moves on tick
    always_comb begin
        prescaler_d = prescaler_q;
        pwm_d       = pwm_q;
        duty_d      = duty_q;
        cnt_d       = cnt_q;
        pos_d       = pos_q;
        dir_d       = dir_q;
        mode_d      = mode_q;
        led_d       = led_q;
        step_d      = 1'b0;
        tick_s      = en && (&prescaler_q);

        if (en) begin
            prescaler_d = prescaler_q + LOG2DELAY'(1);
            pwm_d       = pwm_q + PWM_BITS'(1);
            led_d       = pattern_s;
        end else begin
            led_d       = led_q;
        end

        if (tick_s) begin
            step_d = 1'b1;
            // A new mode restarts its pattern from the beginning instead of advancing
            if (mode_in_s != mode_q) begin
                mode_d = mode_in_s;
                cnt_d  = '0;
                pos_d  = '0;
                dir_d  = DIR_UP;
                duty_d = '0;
            end else begin
                case (mode_q)
                    MODE_GRAY, MODE_BINARY: begin
                        cnt_d = cnt_q + N_LEDS'(1);
                    end
                    MODE_SCAN: begin
                        if (N_LEDS == 1) begin
                            pos_d = '0;
                            dir_d = DIR_UP;
                        end else if (dir_q == DIR_UP) begin
                            if (pos_q == POS_MAX) begin
                                pos_d = pos_q - POS_W'(1);
                                dir_d = DIR_DOWN;
                            end else begin
                                pos_d = pos_q + POS_W'(1);
                            end
                        end else begin
                            if (pos_q == '0) begin
                                pos_d = pos_q + POS_W'(1);
                                dir_d = DIR_UP;
                            end else begin
                                pos_d = pos_q - POS_W'(1);
                            end
                        end
                    end
                    MODE_BREATHE: begin
                        // Triangle: each extreme is shown for exactly one step
                        if (dir_q == DIR_UP) begin
                            if (duty_q == DUTY_MAX) begin
                                duty_d = duty_q - PWM_BITS'(1);
                                dir_d  = DIR_DOWN;
                            end else begin
                                duty_d = duty_q + PWM_BITS'(1);
                            end
                        end else begin
                            if (duty_q == '0) begin
                                duty_d = duty_q + PWM_BITS'(1);
                                dir_d  = DIR_UP;
                            end else begin
                                duty_d = duty_q - PWM_BITS'(1);
                            end
                        end
                    end
                    default: begin
                        cnt_d = cnt_q;
                    end
                endcase
            end
        end else begin
            step_d = 1'b0;
        end
    end

    // State registers with synchronous reset taking priority over enable and tick
    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler_q <= '0;
            pwm_q       <= '0;
            duty_q      <= '0;
            cnt_q       <= '0;
            pos_q       <= '0;
            dir_q       <= DIR_UP;
            mode_q      <= MODE_GRAY;
            led_q       <= '0;
            step_q      <= 1'b0;
        end else begin
            prescaler_q <= prescaler_d;
            pwm_q       <= pwm_d;
            duty_q      <= duty_d;
            cnt_q       <= cnt_d;
            pos_q       <= pos_d;
            dir_q       <= dir_d;
            mode_q      <= mode_d;
            led_q       <= led_d;
            step_q      <= step_d;
        end
    end

endmodule

// File: doc/led_pattern_gen.md
LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

Interface
REQ-001 SHALL have parameter N_LEDS, default 4, number of LED outputs (1..16).
REQ-002 SHALL have parameter LOG2DELAY, default 23, prescaler width; one pattern step occurs every 2^LOG2DELAY enabled cycles.
REQ-003 SHALL have parameter PWM_BITS, default 8, breathe-mode PWM resolution.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-006 SHALL have port en, input, 1, advance enable; 0 freezes all state.
REQ-007 SHALL have port mode, input, 2, requested pattern: 0 GRAY, 1 BINARY, 2 SCAN, 3 BREATHE.
REQ-008 SHALL have port led, output, N_LEDS, registered LED drive; bit 0 = LED 0.
REQ-009 SHALL have port step, output, 1, registered one-cycle pulse per pattern step.

Function
REQ-010 SHALL keep a LOG2DELAY-bit prescaler that increments, wrapping, on each en=1 cycle.
REQ-011 SHALL assert internal tick in the cycle where en=1 and prescaler is all ones.
REQ-012 SHALL drive step high for exactly the one cycle after each tick, otherwise low.
REQ-013 SHALL sample mode into mode_q only on tick; mode changes between ticks have no effect.
REQ-014 SHALL, on a tick where mode differs from mode_q, load mode_q and clear the pattern state (cnt=0, pos=0, dir=up, duty=0) instead of advancing.
REQ-015 SHALL keep an N_LEDS-bit cnt; GRAY and BINARY increment it by 1 per tick, wrapping from all ones to 0.
REQ-016 GRAY: led SHALL equal cnt ^ (cnt >> 1).
REQ-017 BINARY: led SHALL equal cnt.
REQ-018 SCAN: led SHALL be one-hot at bit pos; per tick pos moves one step in dir; at pos=N_LEDS-1 dir goes down, at pos=0 dir goes up; the end LED lights for one step only (0,1,2,3,2,1,0,1 for N_LEDS=4).
REQ-019 SCAN with N_LEDS=1: pos SHALL remain 0, led=1.
REQ-020 BREATHE: a PWM_BITS-bit pwm counter SHALL increment, wrapping, on each en=1 cycle.
REQ-021 BREATHE: duty (PWM_BITS bits) SHALL increase by 1 per tick to all ones, then decrease by 1 per tick to 0, then increase again (triangle; each extreme held one step).
REQ-022 BREATHE: every led bit SHALL equal (pwm < duty), registered; duty=0 gives constant 0.
REQ-023 led SHALL be updated every cycle from the current mode_q and state with one cycle of latency.
REQ-024 en=0 SHALL freeze prescaler, pwm, cnt, pos, dir, duty, mode_q and led; step SHALL be 0.
REQ-025 en toggling SHALL not lose or duplicate steps; the next tick occurs after the remaining enabled cycles.

Reset
REQ-026 On rst=1 at a clock edge: prescaler, pwm, cnt, pos, duty SHALL be 0; dir=up; mode_q=0 (GRAY); led=0; step=0.
REQ-027 rst SHALL take priority over en and tick in the same cycle.
REQ-028 Reset mid-pattern SHALL restart from step 0 of GRAY regardless of the mode input, and the first tick SHALL occur 2^LOG2DELAY enabled cycles after release.

Verification (LOG2DELAY=2, N_LEDS=4, PWM_BITS=3)
REQ-029 rst then en=1, mode=0 held: step every 4 cycles; led sequence 0000,0001,0011,0010,0110, wraps after 16 steps to 0000.
REQ-030 mode=2 applied: first tick loads mode, led=0001; further ticks give 0010,0100,1000,0100,0010,0001,0010.
REQ-031 mode changed 1->2->1 between two ticks: no led or mode_q change until the tick; mode_q stays 1 and cnt advances.
REQ-032 mode=3: after 4 steps duty=4, led high exactly 4 of every 8 cycles; duty reaches 7 then counts 6,5,...,0,1.
REQ-033 en=0 for 10 cycles mid-period (prescaler=2): led and step frozen; next tick 2 enabled cycles after en returns.
REQ-034 rst asserted in a tick cycle in SCAN mode: next cycle led=0000, step=0, mode_q=GRAY.
